imem_loader: RTL and testbench

//  Boot-time writer for the instruction memory. Receives a program as a little-endian

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_word_packer.sv | 40 ++++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the boot-time instruction memory loader.
// Also holds the byte-lane insert helper used when packing words.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int DEFAULT_DEPTH   = 1000;
  localparam int DEFAULT_ADDR_W  = 10;
  localparam int DEFAULT_TIMEOUT = 1024;

  // Little-endian lane insert: byte idx lands in bits [8*idx+7:8*idx].
  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    result[{idx, 3'b000} +: 8] = data;
    return result;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader, bundled together.
// slave is the loader side; master is the byte source / imem side.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// Collects accepted stream bytes into little-endian 32-bit words and emits
// a one-cycle word_valid pulse the cycle after the fourth byte is taken.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [31:0] shift;

  // word is only updated on the fourth byte so it stays stable for the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= 2'd0;
      shift      <= 32'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= accept && !clear && (byte_idx == 2'd3);
      if (clear) begin
        byte_idx <= 2'd0;
        shift    <= 32'd0;
      end else if (accept) begin
        shift    <= pack_byte(shift, byte_idx, byte_data);
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          word <= pack_byte(shift, byte_idx, byte_data);
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into words, writes them to consecutive imem
// addresses and keeps the core held until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len_words,
  imem_loader_if.slave      bus,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] word_idx;
  logic [TO_W-1:0]   idle_cnt;
  logic              accept;
  logic              start_ok;
  logic              write;
  logic              last_word;
  logic              timed_out;
  logic              word_valid;
  logic [31:0]       packed_word;

  assign start_ok  = start && !abort && (state != RECV);
  assign accept    = bus.byte_valid && bus.byte_ready;
  assign write     = word_valid && (state == RECV);
  assign last_word = (({1'b0, word_idx} + ONE_L) == len);
  assign timed_out = !accept && (idle_cnt == TO_LAST);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok || abort),
    .accept     (accept),
    .byte_data  (bus.byte_data),
    .word_valid (word_valid),
    .word       (packed_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        RECV: begin
          if (write && last_word) begin
            next_state = DONE;
          end else if (timed_out) begin
            next_state = ERR;
          end
        end
        default: begin
          if (start_ok) begin
            if (len_words == '0) begin
              next_state = DONE;
            end else if (len_words > DEPTH_L) begin
              next_state = ERR;
            end else begin
              next_state = RECV;
            end
          end
        end
      endcase
    end
  end

  // Ready drops during the write cycle so a new word never overlaps a pending one.
  always_comb begin
    busy           = (state == RECV);
    done           = (state == DONE);
    err            = (state == ERR);
    bus.byte_ready = (state == RECV) && !word_valid;
    bus.imem_we    = write;
  end

  assign bus.imem_addr  = word_idx;
  assign bus.imem_wdata = packed_word;

  // word_idx stops at len-1 on the final write so imem_addr never leaves the image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0;
      word_idx  <= '0;
      idle_cnt  <= '0;
      checksum  <= 32'd0;
      core_hold <= 1'b1;
    end else if (start_ok) begin
      len       <= len_words;
      word_idx  <= '0;
      idle_cnt  <= '0;
      checksum  <= 32'd0;
      core_hold <= 1'b1;
    end else if (state == RECV) begin
      idle_cnt <= accept ? '0 : idle_cnt + TO_W'(1);
      if (write) begin
        checksum <= checksum + packed_word;
        if (last_word) begin
          core_hold <= 1'b0;
        end else begin
          word_idx <= word_idx + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, packing, random gaps, boundaries,
// timeout, abort, ignored start and async reset mid-load.
module tb_imem_loader;

  localparam int DEPTH   = 1000;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [ADDR_W:0] len_words = '0;
  logic            core_hold;
  logic            busy;
  logic            done;
  logic            err;
  logic [31:0]     checksum;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_n     = 0;
  int base;
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .len_words (len_words),
    .bus       (bus),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // Behaves as the imem: captures every write strobe on the rising edge.
  always @(posedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_addr] <= bus.imem_wdata;
      wr_n <= wr_n + 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int len);
    len_words = (ADDR_W + 1)'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    logic rdy;
    logic accepted;
    accepted = 1'b0;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        bus.byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 20 && !accepted; i++) begin
      rdy = bus.byte_ready;
      @(negedge clk);
      accepted = rdy;
    end
    bus.byte_valid = 1'b0;
    check_output("byte_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int addr, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], gaps);
    end
    check_output("write_strobe", {31'd0, bus.imem_we}, 32'd1);
    check_output("write_addr", 32'(bus.imem_addr), 32'(addr));
    check_output("write_data", bus.imem_wdata, w);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    check_output("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    check_output("rst_we", {31'd0, bus.imem_we}, 32'd0);
    check_output("rst_addr", 32'(bus.imem_addr), 32'd0);
    check_output("rst_wdata", bus.imem_wdata, 32'd0);
    check_output("rst_flags", {29'd0, busy, done, err}, 32'd0);
    check_output("rst_checksum", checksum, 32'd0);
    check_output("rst_hold", {31'd0, core_hold}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] two-word load");
    base = wr_n;
    pulse_start(2);
    check_output("t1_busy", {31'd0, busy}, 32'd1);
    check_output("t1_ready", {31'd0, bus.byte_ready}, 32'd1);
    send_word(32'h0000_0013, 0, 1'b0);
    send_word(32'h0010_0093, 1, 1'b0);
    @(negedge clk);
    check_output("t1_done", {29'd0, busy, done, err}, 32'd2);
    check_output("t1_hold", {31'd0, core_hold}, 32'd0);
    check_output("t1_checksum", checksum, 32'h0010_00A6);
    check_output("t1_writes", 32'(wr_n - base), 32'd2);
    check_output("t1_mem0", mem[0], 32'h0000_0013);
    check_output("t1_mem1", mem[1], 32'h0010_0093);
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_output("t1_no_extra", {31'd0, bus.byte_ready}, 32'd0);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    check_output("t1_writes_after", 32'(wr_n - base), 32'd2);

    $display("[TB] three-word load with gaps");
    base = wr_n;
    pulse_start(3);
    send_word(32'h0000_0013, 0, 1'b1);
    send_word(32'h0010_0093, 1, 1'b1);
    send_word(32'h0000_0073, 2, 1'b1);
    @(negedge clk);
    check_output("t2_done", {31'd0, done}, 32'd1);
    check_output("t2_checksum", checksum, 32'h0010_0119);
    check_output("t2_writes", 32'(wr_n - base), 32'd3);
    check_output("t2_mem2", mem[2], 32'h0000_0073);

    $display("[TB] length boundaries");
    base = wr_n;
    pulse_start(0);
    check_output("t3_len0_done", {29'd0, busy, done, err}, 32'd2);
    check_output("t3_len0_checksum", checksum, 32'd0);
    pulse_start(DEPTH + 1);
    check_output("t3_big_err", {29'd0, busy, done, err}, 32'd1);
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_output("t3_big_ready", {30'd0, bus.byte_ready, bus.imem_we}, 32'd0);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    check_output("t3_writes", 32'(wr_n - base), 32'd0);
    check_output("t3_hold", {31'd0, core_hold}, 32'd1);

    $display("[TB] idle timeout");
    pulse_start(1);
    check_output("t4_busy", {29'd0, busy, done, err}, 32'd4);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check_output("t4_before_to", {29'd0, busy, done, err}, 32'd4);
    @(negedge clk);
    check_output("t4_err", {29'd0, busy, done, err}, 32'd1);
    check_output("t4_hold", {31'd0, core_hold}, 32'd1);
    check_output("t4_writes", 32'(wr_n - base), 32'd0);
    pulse_start(1);
    check_output("t4_restart", {31'd0, busy}, 32'd1);

    $display("[TB] start ignored and abort in RECV");
    pulse_start(0);
    check_output("t6_start_ignored", {29'd0, busy, done, err}, 32'd4);
    send_byte(8'hAA, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("t6_abort_idle", {29'd0, busy, done, err}, 32'd0);
    check_output("t6_abort_ready", {31'd0, bus.byte_ready}, 32'd0);
    check_output("t6_abort_hold", {31'd0, core_hold}, 32'd1);

    $display("[TB] async reset mid-load");
    base = wr_n;
    pulse_start(2);
    send_word(32'h1122_3344, 0, 1'b0);
    send_byte(8'h55, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("t5_flags", {29'd0, busy, done, err}, 32'd0);
    check_output("t5_ready", {30'd0, bus.byte_ready, bus.imem_we}, 32'd0);
    check_output("t5_addr", 32'(bus.imem_addr), 32'd0);
    check_output("t5_wdata", bus.imem_wdata, 32'd0);
    check_output("t5_checksum", checksum, 32'd0);
    check_output("t5_hold", {31'd0, core_hold}, 32'd1);
    check_output("t5_mem0", mem[0], 32'h1122_3344);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("t5_writes", 32'(wr_n - base), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
